// File: rtl/tmr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tmr_pkg
//  Description : Shared definitions for the TMR recovery sequencer: state
//                encoding, core indices, voter one-hot masks and the
//                source/target core selection helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package tmr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_COPY    = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_PC_LOAD = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAIL    = 3'd6
    } rec_state_e;

    localparam logic [1:0] CORE_A = 2'd0;
    localparam logic [1:0] CORE_B = 2'd1;
    localparam logic [1:0] CORE_C = 2'd2;

    localparam logic [2:0] MASK_NONE = 3'b000;
    localparam logic [2:0] MASK_A    = 3'b001;
    localparam logic [2:0] MASK_B    = 3'b010;
    localparam logic [2:0] MASK_C    = 3'b100;

    // True when exactly one core is flagged, i.e. the fault is recoverable.
    function automatic logic is_single_fault(input logic [2:0] mask);
        return (mask == MASK_A) || (mask == MASK_B) || (mask == MASK_C);
    endfunction

    // Lowest-index core that is not flagged by the voter.
    function automatic logic [1:0] pick_source(input logic [2:0] mask);
        if ((mask & MASK_A) == MASK_NONE) begin
            return CORE_A;
        end else if ((mask & MASK_B) == MASK_NONE) begin
            return CORE_B;
        end
        return CORE_C;
    endfunction

    // Core index of a one-hot target mask.
    function automatic logic [1:0] mask_to_core(input logic [2:0] mask);
        if (mask == MASK_A) begin
            return CORE_A;
        end else if (mask == MASK_B) begin
            return CORE_B;
        end
        return CORE_C;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_core_mux3.sv
`default_nettype none
// ============================================================================
//  Module      : tmr_core_mux3
//  Description : DATA_W-wide 3:1 selector indexed by core number (A/B/C).
//                An out-of-range index yields zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmr_core_mux3
    import tmr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] data_c,
    output logic [DATA_W-1:0] data_y
);

    // Pick the data of the selected core.
    always_comb begin
        data_y = '0;
        case (sel)
            CORE_A:  data_y = data_a;
            CORE_B:  data_y = data_b;
            CORE_C:  data_y = data_c;
            default: data_y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tmr_recovery_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tmr_recovery_sequencer
//  Description : Copies x1..x31 and the PC from a healthy core into the core
//                flagged by the voter, one register per cycle, while lockstep
//                holds all cores. Pulses rec_done on success; sets the sticky
//                rec_fault on an unrecoverable condition.
//  Options     : RECOVERY_VERIFY_EN - adds a read-back sweep comparing the
//                target against the source before the PC is loaded.
//  Revision    : 1.0 - initial release
// ============================================================================
module tmr_recovery_sequencer
    import tmr_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic [2:0]        Voter_state,
    input  logic              core_hold,
    input  logic [DATA_W-1:0] RD_A,
    input  logic [DATA_W-1:0] RD_B,
    input  logic [DATA_W-1:0] RD_C,
    input  logic [DATA_W-1:0] PC_A,
    input  logic [DATA_W-1:0] PC_B,
    input  logic [DATA_W-1:0] PC_C,
    output logic [ADDR_W-1:0] rec_addr,
    output logic [2:0]        rec_we,
    output logic [DATA_W-1:0] rec_wd,
    output logic [2:0]        rec_pc_we,
    output logic [DATA_W-1:0] rec_pc,
    output logic              rec_busy,
    output logic              rec_done,
    output logic              rec_fault
);

    // x0 is hardwired, so the sweep runs 1..NUM_REGS-1.
    localparam logic [ADDR_W-1:0] c_first_addr = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(NUM_REGS - 1);

    rec_state_e        r_state;
    rec_state_e        w_next_state;
    logic [2:0]        r_tgt;
    logic [1:0]        r_src;
    logic [ADDR_W-1:0] r_addr;

    logic              w_capture_tgt;
    logic              w_load_src;
    logic              w_addr_inc;
    logic              w_addr_restart;

    logic [DATA_W-1:0] w_rd_src;
    logic [DATA_W-1:0] w_pc_src;

    tmr_core_mux3 #(.DATA_W(DATA_W)) u_src_rd_mux (
        .sel    (r_src),
        .data_a (RD_A),
        .data_b (RD_B),
        .data_c (RD_C),
        .data_y (w_rd_src)
    );

    tmr_core_mux3 #(.DATA_W(DATA_W)) u_src_pc_mux (
        .sel    (r_src),
        .data_a (PC_A),
        .data_b (PC_B),
        .data_c (PC_C),
        .data_y (w_pc_src)
    );

`ifdef RECOVERY_VERIFY_EN
    logic [1:0]        w_tgt_core;
    logic [DATA_W-1:0] w_rd_tgt;

    assign w_tgt_core = mask_to_core(r_tgt);

    tmr_core_mux3 #(.DATA_W(DATA_W)) u_tgt_rd_mux (
        .sel    (w_tgt_core),
        .data_a (RD_A),
        .data_b (RD_B),
        .data_c (RD_C),
        .data_y (w_rd_tgt)
    );
`endif

    // State register; reset aborts any recovery in progress.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Target/source/address registers, steered by strobes from the FSM.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            r_tgt  <= MASK_NONE;
            r_src  <= CORE_A;
            r_addr <= '0;
        end else begin
            if (w_capture_tgt) begin
                r_tgt <= Voter_state;
            end
            if (w_load_src) begin
                r_src  <= pick_source(r_tgt);
                r_addr <= c_first_addr;
            end else if (w_addr_restart) begin
                r_addr <= c_first_addr;
            end else if (w_addr_inc) begin
                r_addr <= r_addr + c_first_addr;
            end
        end
    end

    // Next-state logic and Moore outputs; write enables only in their phase.
    always_comb begin
        w_next_state   = r_state;
        w_capture_tgt  = 1'b0;
        w_load_src     = 1'b0;
        w_addr_inc     = 1'b0;
        w_addr_restart = 1'b0;
        rec_addr       = '0;
        rec_we         = 3'b000;
        rec_wd         = '0;
        rec_pc_we      = 3'b000;
        rec_pc         = '0;
        rec_done       = 1'b0;
        rec_fault      = 1'b0;
        rec_busy       = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (core_hold && (Voter_state != MASK_NONE)) begin
                    w_capture_tgt = 1'b1;
                    w_next_state  = ST_LATCH;
                end
            end

            ST_LATCH: begin
                if (!core_hold || !is_single_fault(r_tgt)) begin
                    w_next_state = ST_FAIL;
                end else begin
                    w_load_src   = 1'b1;
                    w_next_state = ST_COPY;
                end
            end

            ST_COPY: begin
                rec_addr = r_addr;
                rec_we   = r_tgt;
                rec_wd   = w_rd_src;
                if (!core_hold) begin
                    w_next_state = ST_FAIL;
                end else if (r_addr == c_last_addr) begin
`ifdef RECOVERY_VERIFY_EN
                    w_addr_restart = 1'b1;
                    w_next_state   = ST_VERIFY;
`else
                    w_next_state   = ST_PC_LOAD;
`endif
                end else begin
                    w_addr_inc = 1'b1;
                end
            end

`ifdef RECOVERY_VERIFY_EN
            ST_VERIFY: begin
                rec_addr = r_addr;
                if (!core_hold || (w_rd_tgt != w_rd_src)) begin
                    w_next_state = ST_FAIL;
                end else if (r_addr == c_last_addr) begin
                    w_next_state = ST_PC_LOAD;
                end else begin
                    w_addr_inc = 1'b1;
                end
            end
`endif

            ST_PC_LOAD: begin
                rec_pc    = w_pc_src;
                rec_pc_we = r_tgt;
                if (!core_hold) begin
                    w_next_state = ST_FAIL;
                end else begin
                    w_next_state = ST_DONE;
                end
            end

            ST_DONE: begin
                rec_done     = 1'b1;
                w_next_state = ST_IDLE;
            end

            ST_FAIL: begin
                rec_fault = 1'b1;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tmr_recovery_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmr_recovery_sequencer
//  Description : Self-checking bench for tmr_recovery_sequencer. Three core
//                register files and PCs live in the bench; a phase-count
//                reference model predicts every output each cycle, and
//                directed plus randomized recoveries pin literal results.
//  Options     : RECOVERY_VERIFY_EN - also exercises the read-back sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tmr_recovery_sequencer;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
`ifdef RECOVERY_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif
    // Phase index k counts cycles since leaving IDLE: 1 latch, 2..32 copy,
    // then (optionally) 31 verify cycles, then PC load, then done.
    localparam int VER_LO = 33;
    localparam int VER_HI = 32 + 31 * VER;
    localparam int DONE_K = 34 + 31 * VER;
    localparam int PC_K   = DONE_K - 1;

    logic              clk = 1'b0;
    logic              rst_in;
    logic [2:0]        Voter_state;
    logic              core_hold;
    logic [DATA_W-1:0] RD_A, RD_B, RD_C, PC_A, PC_B, PC_C;
    logic [ADDR_W-1:0] rec_addr;
    logic [2:0]        rec_we, rec_pc_we;
    logic [DATA_W-1:0] rec_wd, rec_pc;
    logic              rec_busy, rec_done, rec_fault;

    logic [DATA_W-1:0] rf [3][NUM_REGS];
    logic [DATA_W-1:0] pc_reg [3];

    int   checks = 0;
    int   failures = 0;
    int   wr_count = 0;
    int   pcwe_count = 0;
    int   fill_mode = 0;
    bit   corrupt_req = 1'b0;
    bit   tests_done = 1'b0;

    logic [2:0]        p_we = '0, p_pc_we = '0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic [DATA_W-1:0] p_wd = '0, p_pc = '0;

    int         m_k = 0;
    bit         m_fail = 1'b0;
    logic [2:0] m_tgt = '0;
    int         m_src = 0;

    assign RD_A = rf[0][rec_addr];
    assign RD_B = rf[1][rec_addr];
    assign RD_C = rf[2][rec_addr];
    assign PC_A = pc_reg[0];
    assign PC_B = pc_reg[1];
    assign PC_C = pc_reg[2];

    always #5 clk = ~clk;

    tmr_recovery_sequencer #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .Voter_state (Voter_state),
        .core_hold   (core_hold),
        .RD_A        (RD_A),
        .RD_B        (RD_B),
        .RD_C        (RD_C),
        .PC_A        (PC_A),
        .PC_B        (PC_B),
        .PC_C        (PC_C),
        .rec_addr    (rec_addr),
        .rec_we      (rec_we),
        .rec_wd      (rec_wd),
        .rec_pc_we   (rec_pc_we),
        .rec_pc      (rec_pc),
        .rec_busy    (rec_busy),
        .rec_done    (rec_done),
        .rec_fault   (rec_fault)
    );

    function automatic int onehot_idx(input logic [2:0] m);
        return m[0] ? 0 : (m[1] ? 1 : 2);
    endfunction

    function automatic int lowest_healthy(input logic [2:0] m);
        return !m[0] ? 0 : (!m[1] ? 1 : 2);
    endfunction

    function automatic int rf_diffs(input int t, input int s);
        int n = 0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rf[t][i] !== rf[s][i]) n++;
        end
        return n;
    endfunction

    // Expected outputs from the model's phase index.
    function automatic logic [77:0] exp_vec();
        logic              busy = 1'b0, done = 1'b0, fault = 1'b0;
        logic [ADDR_W-1:0] a = '0;
        logic [2:0]        we = '0, pwe = '0;
        logic [DATA_W-1:0] wd = '0, pcv = '0;
        if (m_fail) begin
            busy  = 1'b1;
            fault = 1'b1;
        end else if (m_k != 0) begin
            busy = 1'b1;
            if (m_k >= 2 && m_k <= 32) begin
                a  = ADDR_W'(m_k - 1);
                we = m_tgt;
                wd = rf[m_src][m_k - 1];
            end else if (m_k >= VER_LO && m_k <= VER_HI) begin
                a = ADDR_W'(m_k - 32);
            end else if (m_k == PC_K) begin
                pwe = m_tgt;
                pcv = pc_reg[m_src];
            end else if (m_k == DONE_K) begin
                done = 1'b1;
            end
        end
        return {busy, done, fault, a, we, wd, pwe, pcv};
    endfunction

    // Core register files, PCs and the reference model advance at each edge.
    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (p_we[c])    rf[c][p_addr] <= p_wd;
            if (p_pc_we[c]) pc_reg[c]     <= p_pc;
        end
        if (p_we != 3'b000)    wr_count   <= wr_count + 1;
        if (p_pc_we != 3'b000) pcwe_count <= pcwe_count + 1;
        if (fill_mode == 1) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[0][i] <= DATA_W'(i * 4);
                rf[1][i] <= DATA_W'(i * 8 + 3);
                rf[2][i] <= 32'hC000_0000 | DATA_W'(i);
            end
            pc_reg[0] <= 32'h40;
            pc_reg[1] <= 32'h80;
            pc_reg[2] <= 32'hC0;
        end else if (fill_mode == 2) begin
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < NUM_REGS; i++) rf[c][i] <= $urandom;
                pc_reg[c] <= $urandom;
            end
        end
        if (corrupt_req) rf[1][7] <= rf[1][7] ^ 32'h1;

        if (!rst_in) begin
            m_k    <= 0;
            m_fail <= 1'b0;
        end else if (m_fail) begin
            m_fail <= 1'b1;
        end else if (m_k == 0) begin
            if (core_hold && Voter_state != 3'b000) begin
                m_k   <= 1;
                m_tgt <= Voter_state;
            end
        end else if (m_k == 1) begin
            if (!core_hold || $countones(m_tgt) != 1) begin
                m_fail <= 1'b1;
                m_k    <= 0;
            end else begin
                m_src <= lowest_healthy(m_tgt);
                m_k   <= 2;
            end
        end else if (m_k == DONE_K) begin
            m_k <= 0;
        end else begin
            if (!core_hold) begin
                m_fail <= 1'b1;
                m_k    <= 0;
            end else if (m_k >= VER_LO && m_k <= VER_HI &&
                         rf[onehot_idx(m_tgt)][m_k - 32] !== rf[m_src][m_k - 32]) begin
                m_fail <= 1'b1;
                m_k    <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic compare_loop();
        logic [77:0] e, a;
        while (!tests_done) begin
            @(negedge clk);
            p_we    = rec_we;
            p_addr  = rec_addr;
            p_wd    = rec_wd;
            p_pc_we = rec_pc_we;
            p_pc    = rec_pc;
            e = exp_vec();
            a = {rec_busy, rec_done, rec_fault, rec_addr, rec_we, rec_wd, rec_pc_we, rec_pc};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, a, e);
            end
        end
    endtask

    task automatic fill(input int mode);
        fill_mode = mode;
        @(negedge clk);
        fill_mode = 0;
    endtask

    task automatic pulse_reset();
        rst_in = 1'b0;
        @(negedge clk);
        rst_in = 1'b1;
    endtask

    // Starts at a negedge; lat counts negedges until rec_done/rec_fault.
    task automatic run_recovery(input logic [2:0] tgt, input int drop_at, input int rst_at,
                                input bit noise, output int lat, output bit done_seen,
                                output bit fault_seen);
        bit rst_hit = 1'b0;
        Voter_state = tgt;
        core_hold   = 1'b1;
        lat = 0; done_seen = 1'b0; fault_seen = 1'b0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (rec_done)  begin done_seen  = 1'b1; break; end
            if (rec_fault) begin fault_seen = 1'b1; break; end
            if (noise) Voter_state = 3'($urandom);
            if (rec_we != 3'b000 && drop_at == int'(rec_addr)) core_hold = 1'b0;
            if (rec_we != 3'b000 && rst_at == int'(rec_addr)) begin
                rst_in  = 1'b0;
                rst_hit = 1'b1;
                break;
            end
        end
        check("recovery_end", 64'(done_seen | fault_seen | rst_hit), 64'd1);
        core_hold   = 1'b0;
        Voter_state = 3'b000;
    endtask

    task automatic run_tests();
        int lat, w0, p0;
        bit d, f;
        rst_in = 1'b0; core_hold = 1'b0; Voter_state = 3'b000;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({rec_busy, rec_done, rec_fault, rec_addr, rec_we, rec_pc_we}), 64'd0);
        rst_in = 1'b1;
        @(negedge clk);

        // Core B fault, source A (RD_A = addr*4, PC_A = 0x40).
        fill(1);
        w0 = wr_count; p0 = pcwe_count;
        run_recovery(3'b010, 0, 0, 1'b0, lat, d, f);
        check("b_done", 64'(d), 64'd1);
        check("b_latency", 64'(lat), 64'(34 + 31 * VER));
        check("b_writes", 64'(wr_count - w0), 64'd31);
        check("b_pc_loads", 64'(pcwe_count - p0), 64'd1);
        check("b_rf_copy", 64'(rf_diffs(1, 0)), 64'd0);
        check("b_x31", 64'(rf[1][31]), 64'd124);
        check("b_x0_untouched", 64'(rf[1][0]), 64'd3);
        check("b_pc", 64'(pc_reg[1]), 64'h40);
        @(negedge clk);
        check("b_busy_after_done", 64'(rec_busy), 64'd0);

        // Core A fault, source B.
        fill(1);
        run_recovery(3'b001, 0, 0, 1'b1, lat, d, f);
        check("a_done", 64'(d), 64'd1);
        check("a_x5", 64'(rf[0][5]), 64'd43);
        check("a_rf_copy", 64'(rf_diffs(0, 1)), 64'd0);
        check("a_x0_untouched", 64'(rf[0][0]), 64'd0);
        check("a_pc", 64'(pc_reg[0]), 64'h80);

        // Double fault is unrecoverable and sticky until reset.
        fill(1);
        w0 = wr_count;
        run_recovery(3'b011, 0, 0, 1'b0, lat, d, f);
        check("dbl_fault", 64'(f), 64'd1);
        repeat (5) @(negedge clk);
        check("dbl_sticky", 64'({rec_fault, rec_busy}), 64'b11);
        check("dbl_no_writes", 64'(wr_count - w0), 64'd0);
        pulse_reset();
        check("dbl_cleared", 64'({rec_fault, rec_busy}), 64'd0);

        // Hold lost at addr 10 while restoring core C from A.
        fill(1);
        w0 = wr_count;
        run_recovery(3'b100, 10, 0, 1'b0, lat, d, f);
        check("hold_fault", 64'(f), 64'd1);
        check("hold_writes", 64'(wr_count - w0), 64'd10);
        check("hold_x10", 64'(rf[2][10]), 64'd40);
        check("hold_x11", 64'(rf[2][11]), 64'hC000_000B);
        pulse_reset();

        // Reset mid-copy at addr 15, then a fresh recovery restarts at addr 1.
        fill(1);
        w0 = wr_count;
        run_recovery(3'b010, 0, 15, 1'b0, lat, d, f);
        @(negedge clk);
        check("rst_outputs", 64'({rec_busy, rec_done, rec_fault, rec_addr, rec_we, rec_pc_we}), 64'd0);
        check("rst_writes", 64'(wr_count - w0), 64'd15);
        rst_in = 1'b1;
        Voter_state = 3'b010; core_hold = 1'b1;
        repeat (2) @(negedge clk);
        check("restart_first", 64'({rec_addr, rec_we}), 64'({5'd1, 3'b010}));
        run_recovery(3'b010, 0, 0, 1'b0, lat, d, f);
        check("restart_done", 64'(d), 64'd1);
        check("restart_rf", 64'(rf_diffs(1, 0)), 64'd0);

`ifdef RECOVERY_VERIFY_EN
        // Corrupt target x7 after it was copied; the read-back must catch it.
        fill(1);
        p0 = pcwe_count;
        Voter_state = 3'b010; core_hold = 1'b1;
        lat = 0;
        while (lat < 60 && !(rec_we != 3'b000 && rec_addr == 5'd20)) begin
            @(negedge clk);
            lat++;
        end
        corrupt_req = 1'b1;
        @(negedge clk);
        corrupt_req = 1'b0;
        lat = 0;
        while (lat < 100 && !rec_fault && !rec_done) begin
            @(negedge clk);
            lat++;
        end
        check("verify_fault", 64'({rec_fault, rec_done}), 64'b10);
        check("verify_no_pc", 64'(pcwe_count - p0), 64'd0);
        core_hold = 1'b0; Voter_state = 3'b000;
        pulse_reset();
`endif

        // Randomized data, targets, voter noise and occasional hold loss.
        for (int r = 0; r < 8; r++) begin
            logic [2:0] tgt;
            int drop, t;
            fill(2);
            t    = int'($urandom_range(0, 2));
            tgt  = 3'b001 << t;
            drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 31)) : 0;
            run_recovery(tgt, drop, 0, 1'b1, lat, d, f);
            check("rand_outcome", 64'({d, f}), (drop != 0) ? 64'b01 : 64'b10);
            if (d) begin
                check("rand_rf", 64'(rf_diffs(t, lowest_healthy(tgt))), 64'd0);
                check("rand_pc", 64'(pc_reg[t]), 64'(pc_reg[lowest_healthy(tgt)]));
                @(negedge clk);
            end else begin
                pulse_reset();
            end
        end
        tests_done = 1'b1;
    endtask

    initial begin
        rst_in = 1'b0; core_hold = 1'b0; Voter_state = 3'b000;
        fork
            compare_loop();
            run_tests();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
